// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the async FIFO write-side arbiter.
// Imported by the round-robin picker and the arbiter top.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BEATS = 16;

  // Index width for a requester number; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter must be able to hold MAX_BEATS itself.
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above
// prio_ptr, wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int OW    = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    prio_ptr,
  output logic [OW-1:0]    winner,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(prio_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with packet locking and a beat-count
// watchdog, feeding the async FIFO write side in the w_clk domain.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                     w_clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         ack,
  input  logic                     full,
  output logic                     wr_rq,
  output logic [WIDTH-1:0]         wdata,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     err_overrun
);

  localparam int OW = owner_w(N_REQ);
  localparam int CW = cnt_w(MAX_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);
  localparam logic [OW-1:0] TOP_IDX  = OW'(N_REQ - 1);

  // Handshake: a beat transfers in any cycle where ack[k] is high; ack[k]
  // only rises for the lock owner k, while it asserts req[k] and full is low.
  // wr_rq mirrors that transfer so the FIFO never sees a write while full.

  arb_state_t    state;
  logic [OW-1:0] prio_ptr;
  logic [CW-1:0] beat_cnt;
  logic [OW-1:0] winner;
  logic          any_req;
  logic          accept;
  logic [OW-1:0] next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req      (req),
    .prio_ptr (prio_ptr),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign accept   = (state == LOCK) && req[owner] && !full;
  assign next_ptr = (owner == TOP_IDX) ? '0 : owner + 1'b1;
  assign wr_rq    = accept;
  assign busy     = (state == LOCK);

  always_comb begin
    ack   = '0;
    wdata = '0;
    if (accept) begin
      ack[owner] = 1'b1;
      wdata      = req_data[int'(owner)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      prio_ptr    <= '0;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= winner;
            state    <= LOCK;
            beat_cnt <= '0;
          end
        end
        LOCK: begin
          if (accept) begin
            if (req_last[owner]) begin
              state    <= IDLE;
              prio_ptr <= next_ptr;
              beat_cnt <= '0;
            end else if (beat_cnt == LAST_CNT) begin
              // Packet ran past the watchdog limit: force the port free.
              state       <= IDLE;
              prio_ptr    <= next_ptr;
              beat_cnt    <= '0;
              err_overrun <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter with a packet-level
// reference model and directed scenarios for locking, backpressure and reset.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;
  localparam int OW = 2;

  // ---------------- clock / reset ----------------
  logic           w_clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic           full;
  logic           wr_rq;
  logic [W-1:0]   wdata;
  logic [OW-1:0]  owner;
  logic           busy;
  logic           err_overrun;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BEATS(MB)) dut (
    .w_clk       (w_clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .full        (full),
    .wr_rq       (wr_rq),
    .wdata       (wdata),
    .owner       (owner),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [OW+W-1:0] exp_q[$];     // {requester, data} per expected write
  logic [OW+2:0]   exp_st_q[$];  // {busy, owner, err_overrun, wr_rq} per cycle
  logic [W:0]      src_q[N][$];  // per-requester beats {last, data}
  logic [N-1:0]    en;
  bit              mon_en = 1'b0;

  // Reference model: -1 means nobody holds the port.
  int m_holder = -1;
  int m_last_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_pkt(input int r, input int len, input int base);
    logic [W-1:0] d;
    for (int j = 0; j < len; j++) begin
      d = (base < 0) ? W'($urandom_range(0, 255)) : W'(base + j);
      src_q[r].push_back({(j == len - 1), d});
    end
  endtask

  // ---------------- driver + model, one call per clock cycle ----------------
  task automatic cycle(input logic f);
    bit          wr_e;
    bit          err_n;
    bit          found;
    int          c;
    logic [W:0]  beat;
    @(posedge w_clk);
    #1;
    full = f;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 && en[i]) begin
        req[i]            = 1'b1;
        req_data[i*W +: W] = src_q[i][0][W-1:0];
        req_last[i]       = src_q[i][0][W];
      end else begin
        req[i]            = 1'b0;
        req_data[i*W +: W] = W'($urandom_range(0, 255));
        req_last[i]       = 1'($urandom_range(0, 1));
      end
    end
    wr_e = (m_holder >= 0) && req[m_holder] && !f;
    exp_st_q.push_back({(m_holder >= 0), OW'(m_last_owner), m_err, wr_e});
    err_n = 1'b0;
    if (m_holder < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && req[c]) begin
          found        = 1'b1;
          m_holder     = c;
          m_last_owner = c;
          m_cnt        = 0;
        end
      end
    end else if (wr_e) begin
      beat = src_q[m_holder].pop_front();
      exp_q.push_back({OW'(m_holder), beat[W-1:0]});
      m_cnt++;
      if (beat[W]) begin
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
      end else if (m_cnt == MB) begin
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
        err_n    = 1'b1;
      end
    end
    m_err  = err_n;
    mon_en = 1'b1;
  endtask

  task automatic drain(input bit rnd_full);
    int n;
    n  = 0;
    en = '1;
    while (pending() && n < 3000) begin
      cycle(rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(pending()), 32'd0);
    repeat (3) cycle(1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    req    = '0;
    req_last = '0;
    req_data = '0;
    full   = 1'b0;
    #1;
    chk("rst_wr_rq", 32'(wr_rq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    exp_q.delete();
    exp_st_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    m_holder = -1; m_last_owner = 0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    @(posedge w_clk);
    @(posedge w_clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [OW+2:0]   st;
  logic [OW+W-1:0] item;

  always @(negedge w_clk) begin
    if (mon_en && rst_n) begin
      if (exp_st_q.size() == 0) begin
        chk("status_underflow", 32'd1, 32'd0);
      end else begin
        st = exp_st_q.pop_front();
        chk("status", 32'({busy, owner, err_overrun, wr_rq}), 32'(st));
      end
      chk("wr_eq_or_ack", 32'(wr_rq), 32'(|ack));
      chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      chk("wr_while_full", 32'(wr_rq & full), 32'd0);
      if (wr_rq) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 32'd1, 32'd0);
        end else begin
          item = exp_q.pop_front();
          chk("ack", 32'(ack), 32'(4'b0001 << item[OW+W-1:W]));
          chk("wdata", 32'(wdata), 32'(item[W-1:0]));
        end
      end else begin
        chk("idle_wdata", 32'(wdata), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int r;
    en = '1;
    do_reset();

    // Single 3-beat packet on requester 2.
    push_pkt(2, 3, 8'hA1);
    drain(1'b0);

    // Round-robin: one-beat packets everywhere, plus a second on requester 0.
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'h10 + i);
    push_pkt(0, 1, 8'h20);
    drain(1'b0);

    // Backpressure mid-packet on requester 1.
    push_pkt(1, 4, 8'h40);
    en = 4'b0010;
    n = 0;
    while (src_q[1].size() > 2 && n < 50) begin cycle(1'b0); n++; end
    chk("bp_progress", 32'(src_q[1].size()), 32'd2);
    repeat (4) cycle(1'b1);
    drain(1'b0);

    // Watchdog: requester 0 streams 20 beats, requester 1 waits behind it.
    push_pkt(0, 20, 8'h60);
    en = 4'b0001;
    n = 0;
    while (m_holder != 0 && n < 20) begin cycle(1'b0); n++; end
    chk("wd_grant", 32'(m_holder), 32'd0);
    push_pkt(1, 2, 8'h90);
    drain(1'b0);

    // Requester 3 drops req for 5 cycles mid-packet while others compete.
    push_pkt(3, 4, 8'hC0);
    en = 4'b1000;
    n = 0;
    while (m_holder != 3 && n < 20) begin cycle(1'b0); n++; end
    push_pkt(0, 1, 8'hD0);
    push_pkt(2, 1, 8'hD2);
    en = '1;
    n = 0;
    while (src_q[3].size() > 2 && n < 50) begin cycle(1'b0); n++; end
    chk("drop_progress", 32'(src_q[3].size()), 32'd2);
    en[3] = 1'b0;
    repeat (5) cycle(1'b0);
    drain(1'b0);

    // Reset while beat 2 of a packet is on the port.
    push_pkt(2, 4, 8'hE0);
    n = 0;
    while (src_q[2].size() > 3 && n < 50) begin cycle(1'b0); n++; end
    cycle(1'b0);
    #2;
    do_reset();
    push_pkt(3, 1, 8'hF3);
    push_pkt(0, 1, 8'hF0);
    drain(1'b0);

    // Randomized traffic with random gaps and backpressure.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, N - 1);
        if (src_q[r].size() < 40) push_pkt(r, $urandom_range(1, 20), -1);
      end
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
      cycle($urandom_range(0, 3) == 0);
    end
    drain(1'b1);

    @(negedge w_clk);
    #1;
    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    chk("exp_st_q_left", 32'(exp_st_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
